// File: rtl/hpdcache_mem_write_buffer_pkg.sv
// Default header/beat/response types and counter sizing for the memory write buffer.
// The top is type-parameterised; these types are only the defaults.
package hpdcache_mem_write_buffer_pkg;

  localparam int unsigned MEM_ID_W   = 4;
  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 64;
  localparam int unsigned MEM_LEN_W  = 8;
  localparam int unsigned MEM_SIZE_W = 3;

  typedef enum logic [1:0] {
    MEM_READ   = 2'b00,
    MEM_WRITE  = 2'b01,
    MEM_ATOMIC = 2'b10
  } mem_command_e;

  typedef struct packed {
    logic [MEM_ID_W-1:0]   mem_req_id;
    logic [MEM_ADDR_W-1:0] mem_req_addr;
    logic [MEM_LEN_W-1:0]  mem_req_len;
    logic [MEM_SIZE_W-1:0] mem_req_size;
    mem_command_e          mem_req_command;
    logic [3:0]            mem_req_atomic;
    logic                  mem_req_cacheable;
    logic [1:0]            mem_req_coherence;
  } wbuf_mem_req_t;

  typedef struct packed {
    logic [MEM_DATA_W-1:0]   mem_req_w_data;
    logic [MEM_DATA_W/8-1:0] mem_req_w_be;
    logic                    mem_req_w_last;
  } wbuf_mem_req_w_t;

  typedef struct packed {
    logic [1:0]          mem_resp_w_error;
    logic [MEM_ID_W-1:0] mem_resp_w_id;
    logic                mem_resp_w_is_atomic;
  } wbuf_mem_resp_w_t;

  // Width of a counter that must hold 0..n inclusive.
  function automatic int unsigned cnt_w(int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/hpdcache_mem_wbuf_fifo.sv
// Registered circular FIFO, no bypass: a pushed entry is visible on rdata_o the next cycle.
// A push while full is dropped even if a pop happens in the same cycle.
module hpdcache_mem_wbuf_fifo #(
  parameter type         T     = logic [7:0],
  parameter int unsigned DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  T     wdata_i,
  input  logic pop_i,
  output T     rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  T              mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_nxt(wptr_q);
      if (do_pop)  rptr_q <= ptr_nxt(rptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: it is only observed through a non-empty count.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/hpdcache_mem_write_buffer.sv
// Write-path decoupling buffer: header/data FIFOs, outstanding-write limit, header-before-data
// ordering via a burst credit, combinational response pass-through. HPDCACHE_MEM_WBUF_LEN_CHECK_EN adds a burst-length checker.
module hpdcache_mem_write_buffer
  import hpdcache_mem_write_buffer_pkg::*;
#(
  parameter type         hpdcache_mem_req_t    = wbuf_mem_req_t,
  parameter type         hpdcache_mem_req_w_t  = wbuf_mem_req_w_t,
  parameter type         hpdcache_mem_resp_w_t = wbuf_mem_resp_w_t,
  parameter int unsigned REQ_FIFO_DEPTH        = 2,
  parameter int unsigned DATA_FIFO_DEPTH       = 4,
  parameter int unsigned MAX_OUTSTANDING       = 8
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,

  output logic                                     req_ready_o,
  input  logic                                     req_valid_i,
  input  hpdcache_mem_req_t                        req_i,

  output logic                                     req_data_ready_o,
  input  logic                                     req_data_valid_i,
  input  hpdcache_mem_req_w_t                      req_data_i,

  input  logic                                     mem_req_ready_i,
  output logic                                     mem_req_valid_o,
  output hpdcache_mem_req_t                        mem_req_o,

  input  logic                                     mem_req_data_ready_i,
  output logic                                     mem_req_data_valid_o,
  output hpdcache_mem_req_w_t                      mem_req_data_o,

  output logic                                     mem_resp_ready_o,
  input  logic                                     mem_resp_valid_i,
  input  hpdcache_mem_resp_w_t                     mem_resp_i,

  input  logic                                     resp_ready_i,
  output logic                                     resp_valid_o,
  output hpdcache_mem_resp_w_t                     resp_o,

  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_o,
  output logic                                     idle_o,
  output logic                                     len_err_o
);

  localparam int unsigned OW = cnt_w(MAX_OUTSTANDING);

  logic          hdr_full, hdr_empty, data_full, data_empty;
  logic          hdr_hs, data_hs, last_hs, resp_hs, resp_dec;
  logic [OW-1:0] outstanding_q, credit_q;

  hpdcache_mem_wbuf_fifo #(
    .T     (hpdcache_mem_req_t),
    .DEPTH (REQ_FIFO_DEPTH)
  ) u_hdr_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (req_valid_i),
    .wdata_i (req_i),
    .pop_i   (hdr_hs),
    .rdata_o (mem_req_o),
    .full_o  (hdr_full),
    .empty_o (hdr_empty)
  );

  hpdcache_mem_wbuf_fifo #(
    .T     (hpdcache_mem_req_w_t),
    .DEPTH (DATA_FIFO_DEPTH)
  ) u_data_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (req_data_valid_i),
    .wdata_i (req_data_i),
    .pop_i   (data_hs),
    .rdata_o (mem_req_data_o),
    .full_o  (data_full),
    .empty_o (data_empty)
  );

  assign req_ready_o      = !hdr_full;
  assign req_data_ready_o = !data_full;

  assign mem_req_valid_o      = !hdr_empty && (outstanding_q < OW'(MAX_OUTSTANDING));
  // Beats wait for a header already issued whose last beat has not gone out.
  assign mem_req_data_valid_o = !data_empty && (credit_q != '0);

  assign hdr_hs  = mem_req_valid_o && mem_req_ready_i;
  assign data_hs = mem_req_data_valid_o && mem_req_data_ready_i;
  assign last_hs = data_hs && mem_req_data_o.mem_req_w_last;

  assign resp_valid_o     = mem_resp_valid_i;
  assign mem_resp_ready_o = resp_ready_i;
  assign resp_o           = mem_resp_i;
  assign resp_hs          = mem_resp_valid_i && resp_ready_i;
  // A stray response at zero is ignored rather than wrapping the counter.
  assign resp_dec         = resp_hs && (outstanding_q != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
      credit_q      <= '0;
    end else begin
      case ({hdr_hs, resp_dec})
        2'b10:   outstanding_q <= outstanding_q + OW'(1);
        2'b01:   outstanding_q <= outstanding_q - OW'(1);
        default: outstanding_q <= outstanding_q;
      endcase
      case ({hdr_hs, last_hs})
        2'b10:   credit_q <= credit_q + OW'(1);
        2'b01:   credit_q <= credit_q - OW'(1);
        default: credit_q <= credit_q;
      endcase
    end
  end

  assign outstanding_o = outstanding_q;
  assign idle_o        = hdr_empty && data_empty && (outstanding_q == '0) && (credit_q == '0);

  resp_underflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(resp_hs && (outstanding_q == '0)));

`ifdef HPDCACHE_MEM_WBUF_LEN_CHECK_EN
  logic [7:0] len_head, beat_q;
  logic       len_full, len_empty, len_err_q;

  // Lengths of issued headers, consumed in order as their last beats leave.
  hpdcache_mem_wbuf_fifo #(
    .T     (logic [7:0]),
    .DEPTH (MAX_OUTSTANDING)
  ) u_len_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (hdr_hs && !len_full),
    .wdata_i (8'(mem_req_o.mem_req_len)),
    .pop_i   (last_hs),
    .rdata_o (len_head),
    .full_o  (len_full),
    .empty_o (len_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_q    <= '0;
      len_err_q <= 1'b0;
    end else if (data_hs) begin
      if (mem_req_data_o.mem_req_w_last) begin
        beat_q <= '0;
        if (len_empty || (beat_q != len_head)) len_err_q <= 1'b1;
      end else begin
        beat_q <= beat_q + 8'd1;
        if (len_empty || (beat_q == len_head)) len_err_q <= 1'b1;
      end
    end
  end

  assign len_err_o = len_err_q;
`else
  assign len_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_hpdcache_mem_write_buffer.sv
// Self-checking bench: queue-level model of the write buffer compared every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_hpdcache_mem_write_buffer;
  import hpdcache_mem_write_buffer_pkg::*;

  localparam int REQ_D  = 2;
  localparam int DATA_D = 4;
  localparam int MAXO   = 2;
  localparam int OW     = $clog2(MAXO + 1);
`ifdef HPDCACHE_MEM_WBUF_LEN_CHECK_EN
  localparam bit LEN_EN = 1'b1;
`else
  localparam bit LEN_EN = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic             req_ready_o, req_valid_i;
  wbuf_mem_req_t    req_i;
  logic             req_data_ready_o, req_data_valid_i;
  wbuf_mem_req_w_t  req_data_i;
  logic             mem_req_ready_i, mem_req_valid_o;
  wbuf_mem_req_t    mem_req_o;
  logic             mem_req_data_ready_i, mem_req_data_valid_o;
  wbuf_mem_req_w_t  mem_req_data_o;
  logic             mem_resp_ready_o, mem_resp_valid_i;
  wbuf_mem_resp_w_t mem_resp_i;
  logic             resp_ready_i, resp_valid_o;
  wbuf_mem_resp_w_t resp_o;
  logic [OW-1:0]    outstanding_o;
  logic             idle_o, len_err_o;

  hpdcache_mem_write_buffer #(
    .REQ_FIFO_DEPTH  (REQ_D),
    .DATA_FIFO_DEPTH (DATA_D),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .req_ready_o          (req_ready_o),
    .req_valid_i          (req_valid_i),
    .req_i                (req_i),
    .req_data_ready_o     (req_data_ready_o),
    .req_data_valid_i     (req_data_valid_i),
    .req_data_i           (req_data_i),
    .mem_req_ready_i      (mem_req_ready_i),
    .mem_req_valid_o      (mem_req_valid_o),
    .mem_req_o            (mem_req_o),
    .mem_req_data_ready_i (mem_req_data_ready_i),
    .mem_req_data_valid_o (mem_req_data_valid_o),
    .mem_req_data_o       (mem_req_data_o),
    .mem_resp_ready_o     (mem_resp_ready_o),
    .mem_resp_valid_i     (mem_resp_valid_i),
    .mem_resp_i           (mem_resp_i),
    .resp_ready_i         (resp_ready_i),
    .resp_valid_o         (resp_valid_o),
    .resp_o               (resp_o),
    .outstanding_o        (outstanding_o),
    .idle_o               (idle_o),
    .len_err_o            (len_err_o)
  );

  // Upstream sources and model state
  wbuf_mem_req_t   hdr_src[$], hdr_q[$];
  wbuf_mem_req_w_t dat_src[$], dat_q[$];
  int len_q[$];
  int outs, credit, last_done, resp_done, beat;
  bit err;
  int total = 0, bad = 0;
  int p_hv, p_dv, p_mr, p_mdr, p_rv, p_rr;
  bit hv_hold, dv_hold, rv_hold;
  bit e_rr, e_drr, e_mv, e_dv;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit rnd(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  task automatic knobs(input int hv, input int dv, input int mr, input int mdr, input int rv, input int rr);
    p_hv = hv; p_dv = dv; p_mr = mr; p_mdr = mdr; p_rv = rv; p_rr = rr;
  endtask

  task automatic add_txn(input int len, input int nbeats);
    wbuf_mem_req_t   h;
    wbuf_mem_req_w_t b;
    h.mem_req_id        = 4'($urandom);
    h.mem_req_addr      = $urandom;
    h.mem_req_len       = 8'(len);
    h.mem_req_size      = 3'd3;
    h.mem_req_command   = MEM_WRITE;
    h.mem_req_atomic    = 4'($urandom);
    h.mem_req_cacheable = 1'($urandom);
    h.mem_req_coherence = 2'($urandom);
    hdr_src.push_back(h);
    for (int i = 0; i < nbeats; i++) begin
      b.mem_req_w_data = {$urandom, $urandom};
      b.mem_req_w_be   = 8'($urandom);
      b.mem_req_w_last = (i == nbeats - 1);
      dat_src.push_back(b);
    end
  endtask

  task automatic drive();
    req_valid_i      = (hdr_src.size() > 0) && (hv_hold || rnd(p_hv));
    req_i            = (hdr_src.size() > 0) ? hdr_src[0] : '0;
    req_data_valid_i = (dat_src.size() > 0) && (dv_hold || rnd(p_dv));
    req_data_i       = (dat_src.size() > 0) ? dat_src[0] : '0;
    mem_req_ready_i      = rnd(p_mr);
    mem_req_data_ready_i = rnd(p_mdr);
    resp_ready_i         = rnd(p_rr);
    if (!rv_hold) begin
      mem_resp_i.mem_resp_w_error     = 2'($urandom);
      mem_resp_i.mem_resp_w_id        = 4'($urandom);
      mem_resp_i.mem_resp_w_is_atomic = 1'($urandom);
    end
    // Responses only for writes whose last beat has already gone out.
    mem_resp_valid_i = (resp_done < last_done) && (rv_hold || rnd(p_rv));
  endtask

  task automatic settle();
    #1;
    e_rr  = hdr_q.size() < REQ_D;
    e_drr = dat_q.size() < DATA_D;
    e_mv  = (hdr_q.size() > 0) && (outs < MAXO);
    e_dv  = (dat_q.size() > 0) && (credit > 0);
    chk("req_ready", req_ready_o, e_rr);
    chk("req_data_ready", req_data_ready_o, e_drr);
    chk("mem_req_valid", mem_req_valid_o, e_mv);
    if (e_mv) chk("mem_req", mem_req_o, hdr_q[0]);
    chk("mem_req_data_valid", mem_req_data_valid_o, e_dv);
    if (e_dv) chk("mem_req_data", mem_req_data_o, dat_q[0]);
    chk("outstanding", outstanding_o, 128'(outs));
    chk("idle", idle_o, (hdr_q.size() == 0) && (dat_q.size() == 0) && (outs == 0) && (credit == 0));
    chk("len_err", len_err_o, LEN_EN && err);
    chk("resp_valid", resp_valid_o, mem_resp_valid_i);
    chk("mem_resp_ready", mem_resp_ready_o, resp_ready_i);
    chk("resp", resp_o, mem_resp_i);
  endtask

  task automatic tick();
    bit hp, dp, hi, di, rh;
    wbuf_mem_req_w_t b;
    hp = req_valid_i && e_rr;
    dp = req_data_valid_i && e_drr;
    hi = e_mv && mem_req_ready_i;
    di = e_dv && mem_req_data_ready_i;
    rh = mem_resp_valid_i && resp_ready_i;
    hv_hold = req_valid_i && !hp;
    dv_hold = req_data_valid_i && !dp;
    rv_hold = mem_resp_valid_i && !rh;
    @(posedge clk_i);
    if (hi) begin
      len_q.push_back(int'(hdr_q[0].mem_req_len));
      void'(hdr_q.pop_front());
      outs++;
      credit++;
    end
    if (hp) hdr_q.push_back(hdr_src.pop_front());
    if (di) begin
      b = dat_q.pop_front();
      if (b.mem_req_w_last) begin
        if (len_q.size() == 0 || beat != len_q[0]) err = 1'b1;
        if (len_q.size() > 0) void'(len_q.pop_front());
        beat = 0;
        credit--;
        last_done++;
      end else begin
        if (len_q.size() == 0 || beat == len_q[0]) err = 1'b1;
        beat++;
      end
    end
    if (dp) dat_q.push_back(dat_src.pop_front());
    if (rh) begin
      resp_done++;
      if (outs > 0) outs--;
    end
    @(negedge clk_i);
  endtask

  task automatic prep();
    drive();
    settle();
  endtask

  task automatic step();
    prep();
    tick();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    knobs(100, 100, 100, 100, 100, 100);
    while (!(hdr_src.size() == 0 && dat_src.size() == 0 && hdr_q.size() == 0 && dat_q.size() == 0 &&
             outs == 0 && credit == 0 && resp_done == last_done) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d cycles expected below %0d", n, budget);
    end
    chk("drain_idle", idle_o, 1'b1);
  endtask

  task automatic do_reset();
    req_valid_i = 1'b0; req_data_valid_i = 1'b0; mem_resp_valid_i = 1'b0;
    mem_req_ready_i = 1'b0; mem_req_data_ready_i = 1'b0; resp_ready_i = 1'b0;
    rst_ni = 1'b0;
    hdr_src.delete(); dat_src.delete(); hdr_q.delete(); dat_q.delete(); len_q.delete();
    outs = 0; credit = 0; last_done = 0; resp_done = 0; beat = 0; err = 1'b0;
    hv_hold = 1'b0; dv_hold = 1'b0; rv_hold = 1'b0;
    #1;
    chk("rst_mem_req_valid", mem_req_valid_o, 1'b0);
    chk("rst_mem_req_data_valid", mem_req_data_valid_o, 1'b0);
    chk("rst_req_ready", req_ready_o, 1'b1);
    chk("rst_req_data_ready", req_data_ready_o, 1'b1);
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_idle", idle_o, 1'b1);
    chk("rst_len_err", len_err_o, 1'b0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    #2_000_000;
    bad++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    req_i = '0; req_data_i = '0; mem_resp_i = '0;
    do_reset();

    // Single write, len 3, four beats
    knobs(100, 0, 100, 100, 0, 100);
    add_txn(3, 4);
    step();
    p_dv = 100;
    prep(); chk("s1_hdr_latency", mem_req_valid_o, 1'b1); tick();
    repeat (6) step();
    prep(); chk("s1_outstanding", outstanding_o, 1); chk("s1_busy", idle_o, 1'b0); tick();
    p_rv = 100;
    prep(); chk("s1_resp_valid", resp_valid_o, 1'b1); tick();
    p_rv = 0;
    prep(); chk("s1_outs_zero", outstanding_o, 0); chk("s1_idle", idle_o, 1'b1); tick();

    // Data pushed ahead of its header
    knobs(0, 100, 100, 100, 0, 100);
    add_txn(3, 4);
    for (int i = 0; i < 5; i++) begin
      prep();
      chk("s2_data_gated", mem_req_data_valid_o, 1'b0);
      if (i == 4) chk("s2_data_full", req_data_ready_o, 1'b0);
      tick();
    end
    p_hv = 100;
    prep(); chk("s2_push_cycle", mem_req_data_valid_o, 1'b0); tick();
    prep(); chk("s2_hdr_valid", mem_req_valid_o, 1'b1); chk("s2_hs_cycle", mem_req_data_valid_o, 1'b0); tick();
    for (int i = 0; i < 4; i++) begin
      prep(); chk("s2_beat_stream", mem_req_data_valid_o, 1'b1); tick();
    end
    prep(); chk("s2_beats_done", mem_req_data_valid_o, 1'b0); tick();
    drain(200);

    // Outstanding limit, then issue and response in one cycle
    knobs(100, 100, 100, 100, 0, 100);
    repeat (3) add_txn(0, 1);
    repeat (3) step();
    prep(); chk("s3_held", mem_req_valid_o, 1'b0); chk("s3_outs_max", outstanding_o, 2); tick();
    p_rv = 100;
    prep(); chk("s3_still_held", mem_req_valid_o, 1'b0); tick();
    p_rv = 0;
    prep(); chk("s3_released", mem_req_valid_o, 1'b1); chk("s3_outs_one", outstanding_o, 1); tick();
    add_txn(0, 1);
    p_rv = 100;
    step();
    prep();
    chk("s4_outs_before", outstanding_o, 1);
    chk("s4_issue", mem_req_valid_o, 1'b1);
    chk("s4_resp", resp_valid_o, 1'b1);
    tick();
    p_rv = 0;
    prep(); chk("s4_outs_same", outstanding_o, 1); tick();
    drain(200);

    // Downstream stall with six headers queued upstream
    knobs(100, 0, 0, 100, 0, 100);
    repeat (6) add_txn(0, 1);
    for (int i = 0; i < 10; i++) begin
      prep();
      if (i == 2) chk("s5_backpressure", req_ready_o, 1'b0);
      tick();
    end
    drain(300);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      int l;
      l = int'($urandom_range(3));
      add_txn(l, l + 1);
    end
    for (int n = 0; n < 4000 && (hdr_src.size() > 0 || dat_src.size() > 0); n++) begin
      if (n % 50 == 0)
        knobs(int'($urandom_range(100, 20)), int'($urandom_range(100, 20)), int'($urandom_range(100, 20)),
              int'($urandom_range(100, 20)), int'($urandom_range(100, 10)), int'($urandom_range(100, 20)));
      step();
    end
    drain(1000);

    // Length mismatch: len 1 with last on beat 0
    knobs(100, 100, 100, 100, 100, 100);
    add_txn(1, 1);
    repeat (3) step();
    prep(); chk("s6_len_err", len_err_o, LEN_EN); tick();
    drain(200);
    chk("s6_len_err_sticky", len_err_o, LEN_EN);

    // Reset in the middle of a burst
    knobs(100, 100, 100, 100, 0, 100);
    add_txn(3, 4);
    repeat (3) step();
    do_reset();
    add_txn(2, 3);
    drain(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
